// File: rtl/wb_write_arbiter_if.sv
// rtl/wb_write_arbiter_if.sv - bus bundle between writeback sources, decode and the register-file write port
// Ports (slave = arbiter side):
//   pipeline writeback : pipe_we, pipe_rd, pipe_data in; pipe_stall out
//   mult/div handshake : md_valid, md_rd, md_data in; md_ready out
//   hazard lookup      : ctrl_readRegA/B in; hazard_A/B out
//   register file      : ctrl_writeEnable, ctrl_writeReg, data_writeReg out
interface wb_write_arbiter_if;
    logic        pipe_we;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        pipe_stall;
    logic        md_valid;
    logic [4:0]  md_rd;
    logic [31:0] md_data;
    logic        md_ready;
    logic [4:0]  ctrl_readRegA;
    logic [4:0]  ctrl_readRegB;
    logic        hazard_A;
    logic        hazard_B;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;

    modport slave (
        input  pipe_we, pipe_rd, pipe_data, md_valid, md_rd, md_data,
               ctrl_readRegA, ctrl_readRegB,
        output pipe_stall, md_ready, hazard_A, hazard_B,
               ctrl_writeEnable, ctrl_writeReg, data_writeReg
    );

    modport master (
        output pipe_we, pipe_rd, pipe_data, md_valid, md_rd, md_data,
               ctrl_readRegA, ctrl_readRegB,
        input  pipe_stall, md_ready, hazard_A, hazard_B,
               ctrl_writeEnable, ctrl_writeReg, data_writeReg
    );
endinterface

// File: rtl/wb_write_arbiter.sv
// rtl/wb_write_arbiter.sv - merges pipeline and buffered mult/div results onto one register-file write port
// Ports:
//   clock        : rising-edge clock
//   ctrl_reset_n : asynchronous active-low reset
//   bus          : wb_write_arbiter_if.slave (pipe, mult/div, hazard and write-port signals)
// Pipe writes always win; mult/div results wait in a 2-entry FIFO, are squashed by
// younger pipe writes to the same rd, and force a pipe stall once the head ages out.
module wb_write_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clock,
    input  logic                 ctrl_reset_n,
    wb_write_arbiter_if.slave    bus
);

    logic [1:0]  fifo_vld_q, fifo_vld_d;
    logic [4:0]  fifo_rd_q   [2];
    logic [4:0]  fifo_rd_d   [2];
    logic [31:0] fifo_data_q [2];
    logic [31:0] fifo_data_d [2];
    logic        head_q, head_d;
    logic        tail_q, tail_d;
    logic [1:0]  count_q, count_d;
    logic [3:0]  age_q, age_d;
    logic        out_we_q, out_we_d;
    logic [4:0]  out_reg_q, out_reg_d;
    logic [31:0] out_data_q, out_data_d;

    logic pipe_eff;
    logic md_acc;
    logic push;
    logic pop;
    logic hazard_a, hazard_b;

    assign pipe_eff = bus.pipe_we && (bus.pipe_rd != 5'd0);
    assign md_acc   = bus.md_valid && bus.md_ready;
    // A same-cycle md result to the pipe's rd is older than the pipe write, so it is dropped.
    assign push     = md_acc && (bus.md_rd != 5'd0) && !(pipe_eff && (bus.md_rd == bus.pipe_rd));
    // Pipe owns the port; the FIFO only drains in cycles the pipe leaves idle.
    assign pop      = !pipe_eff && (count_q != 2'd0);

    always_comb begin
        fifo_vld_d  = fifo_vld_q;
        fifo_rd_d   = fifo_rd_q;
        fifo_data_d = fifo_data_q;
        head_d      = head_q;
        tail_d      = tail_q;
        out_we_d    = 1'b0;
        out_reg_d   = out_reg_q;
        out_data_d  = out_data_q;

        if (pipe_eff) begin
            out_we_d   = 1'b1;
            out_reg_d  = bus.pipe_rd;
            out_data_d = bus.pipe_data;
            for (int i = 0; i < 2; i++) begin
                if (fifo_rd_q[i] == bus.pipe_rd) fifo_vld_d[i] = 1'b0;
            end
        end else if (pop) begin
            // A squashed head still costs its pop cycle but produces no write.
            if (fifo_vld_q[head_q]) begin
                out_we_d   = 1'b1;
                out_reg_d  = fifo_rd_q[head_q];
                out_data_d = fifo_data_q[head_q];
            end
            fifo_vld_d[head_q] = 1'b0;
            head_d             = ~head_q;
        end

        if (push) begin
            fifo_vld_d[tail_q]  = 1'b1;
            fifo_rd_d[tail_q]   = bus.md_rd;
            fifo_data_d[tail_q] = bus.md_data;
            tail_d              = ~tail_q;
        end

        count_d = 2'(count_q + {1'b0, push} - {1'b0, pop});

        if (pop || (count_q == 2'd0)) age_d = 4'd0;
        else if (age_q != 4'd15)      age_d = age_q + 4'd1;
        else                          age_d = age_q;
    end

    always_comb begin
        hazard_a = 1'b0;
        hazard_b = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (fifo_vld_q[i] && (fifo_rd_q[i] == bus.ctrl_readRegA)) hazard_a = 1'b1;
            if (fifo_vld_q[i] && (fifo_rd_q[i] == bus.ctrl_readRegB)) hazard_b = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            fifo_vld_q <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                fifo_rd_q[i]   <= 5'd0;
                fifo_data_q[i] <= 32'd0;
            end
            head_q     <= 1'b0;
            tail_q     <= 1'b0;
            count_q    <= 2'd0;
            age_q      <= 4'd0;
            out_we_q   <= 1'b0;
            out_reg_q  <= 5'd0;
            out_data_q <= 32'd0;
        end else begin
            fifo_vld_q  <= fifo_vld_d;
            fifo_rd_q   <= fifo_rd_d;
            fifo_data_q <= fifo_data_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            age_q       <= age_d;
            out_we_q    <= out_we_d;
            out_reg_q   <= out_reg_d;
            out_data_q  <= out_data_d;
        end
    end

    assign bus.md_ready         = (count_q < 2'd2);
    assign bus.pipe_stall       = (age_q >= 4'(STARVE_LIMIT));
    assign bus.hazard_A         = (bus.ctrl_readRegA != 5'd0) && hazard_a;
    assign bus.hazard_B         = (bus.ctrl_readRegB != 5'd0) && hazard_b;
    assign bus.ctrl_writeEnable = out_we_q;
    assign bus.ctrl_writeReg    = out_reg_q;
    assign bus.data_writeReg    = out_data_q;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// tb/tb_wb_write_arbiter.sv - directed self-checking bench for wb_write_arbiter
module tb_wb_write_arbiter;

    logic clock;
    logic ctrl_reset_n;
    int   n_cmp;
    int   n_fail;

    wb_write_arbiter_if bus ();

    wb_write_arbiter #(.STARVE_LIMIT(4)) dut (
        .clock        (clock),
        .ctrl_reset_n (ctrl_reset_n),
        .bus          (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.pipe_we = 1'b0; bus.pipe_rd = 5'd0; bus.pipe_data = 32'd0;
        bus.md_valid = 1'b0; bus.md_rd = 5'd0; bus.md_data = 32'd0;
        bus.ctrl_readRegA = 5'd0; bus.ctrl_readRegB = 5'd0;
    endtask

    task automatic test_reset();
        idle_inputs();
        ctrl_reset_n = 1'b0;
        #12;
        ctrl_reset_n = 1'b1;
        step();
        n_cmp++;
        if ({bus.ctrl_writeEnable, bus.ctrl_writeReg, bus.data_writeReg} !== {1'b0, 5'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL reset_out: got we=%0b reg=%0d data=%h want 0/0/0", bus.ctrl_writeEnable, bus.ctrl_writeReg, bus.data_writeReg);
        end
        n_cmp++;
        if ({bus.md_ready, bus.pipe_stall, bus.hazard_A, bus.hazard_B} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_flags: got rdy/stall/hA/hB=%b want 1000", {bus.md_ready, bus.pipe_stall, bus.hazard_A, bus.hazard_B});
        end
    endtask

    task automatic test_pipe();
        bus.pipe_we = 1'b1; bus.pipe_rd = 5'd5; bus.pipe_data = 32'hDEADBEEF;
        step();
        n_cmp++;
        if ({bus.ctrl_writeEnable, bus.ctrl_writeReg, bus.data_writeReg} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
            n_fail++;
            $display("FAIL pipe_write: got we=%0b reg=%0d data=%h want 1/5/deadbeef", bus.ctrl_writeEnable, bus.ctrl_writeReg, bus.data_writeReg);
        end
        bus.pipe_rd = 5'd0; bus.pipe_data = 32'h12345678;
        step();
        n_cmp++;
        if ({bus.ctrl_writeEnable, bus.ctrl_writeReg, bus.data_writeReg} !== {1'b0, 5'd5, 32'hDEADBEEF}) begin
            n_fail++;
            $display("FAIL pipe_r0: got we=%0b reg=%0d data=%h want 0/5/deadbeef (held)", bus.ctrl_writeEnable, bus.ctrl_writeReg, bus.data_writeReg);
        end
        idle_inputs();
    endtask

    task automatic test_md_r0();
        bus.md_valid = 1'b1; bus.md_rd = 5'd0; bus.md_data = 32'h0BAD;
        step();
        bus.md_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (bus.ctrl_writeEnable !== 1'b0) begin
                n_fail++;
                $display("FAIL md_r0_drop[%0d]: got we=%0b reg=%0d want we=0", k, bus.ctrl_writeEnable, bus.ctrl_writeReg);
            end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_fill_drain();
        bus.pipe_we = 1'b1; bus.pipe_rd = 5'd3; bus.pipe_data = 32'h33;
        bus.md_valid = 1'b1; bus.md_rd = 5'd7; bus.md_data = 32'h11;
        step();
        n_cmp++;
        if ({bus.ctrl_writeEnable, bus.ctrl_writeReg, bus.data_writeReg} !== {1'b1, 5'd3, 32'h33}) begin
            n_fail++;
            $display("FAIL fill_pipe: got we=%0b reg=%0d data=%h want 1/3/33", bus.ctrl_writeEnable, bus.ctrl_writeReg, bus.data_writeReg);
        end
        bus.md_rd = 5'd8; bus.md_data = 32'h22;
        step();
        bus.md_valid = 1'b0;
        bus.ctrl_readRegA = 5'd8; bus.ctrl_readRegB = 5'd7;
        #1;
        n_cmp++;
        if ({bus.md_ready, bus.hazard_A, bus.hazard_B} !== 3'b011) begin
            n_fail++;
            $display("FAIL fill_full: got rdy/hA/hB=%b want 011", {bus.md_ready, bus.hazard_A, bus.hazard_B});
        end
        bus.pipe_we = 1'b0;
        step();
        n_cmp++;
        if ({bus.ctrl_writeEnable, bus.ctrl_writeReg, bus.data_writeReg} !== {1'b1, 5'd7, 32'h11}) begin
            n_fail++;
            $display("FAIL drain_first: got we=%0b reg=%0d data=%h want 1/7/11", bus.ctrl_writeEnable, bus.ctrl_writeReg, bus.data_writeReg);
        end
        step();
        n_cmp++;
        if ({bus.ctrl_writeEnable, bus.ctrl_writeReg, bus.data_writeReg, bus.md_ready, bus.hazard_A} !== {1'b1, 5'd8, 32'h22, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL drain_second: got we=%0b reg=%0d data=%h rdy=%0b hA=%0b want 1/8/22 rdy=1 hA=0", bus.ctrl_writeEnable, bus.ctrl_writeReg, bus.data_writeReg, bus.md_ready, bus.hazard_A);
        end
        step();
        n_cmp++;
        if (bus.ctrl_writeEnable !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_empty: got we=%0b want 0", bus.ctrl_writeEnable);
        end
        idle_inputs();
    endtask

    task automatic test_squash();
        bus.md_valid = 1'b1; bus.md_rd = 5'd9; bus.md_data = 32'hAAAA;
        step();
        bus.md_valid = 1'b0;
        bus.ctrl_readRegA = 5'd9;
        bus.pipe_we = 1'b1; bus.pipe_rd = 5'd9; bus.pipe_data = 32'hBBBB;
        #1;
        n_cmp++;
        if (bus.hazard_A !== 1'b1) begin
            n_fail++;
            $display("FAIL squash_hazard_pre: got hA=%0b want 1", bus.hazard_A);
        end
        step();
        bus.pipe_we = 1'b0;
        n_cmp++;
        if ({bus.ctrl_writeEnable, bus.ctrl_writeReg, bus.data_writeReg, bus.hazard_A} !== {1'b1, 5'd9, 32'hBBBB, 1'b0}) begin
            n_fail++;
            $display("FAIL squash_pipe: got we=%0b reg=%0d data=%h hA=%0b want 1/9/bbbb hA=0", bus.ctrl_writeEnable, bus.ctrl_writeReg, bus.data_writeReg, bus.hazard_A);
        end
        for (int k = 0; k < 2; k++) begin
            step();
            n_cmp++;
            if (bus.ctrl_writeEnable !== 1'b0) begin
                n_fail++;
                $display("FAIL squash_nowrite[%0d]: got we=%0b reg=%0d data=%h want we=0", k, bus.ctrl_writeEnable, bus.ctrl_writeReg, bus.data_writeReg);
            end
        end
        idle_inputs();
    endtask

    task automatic test_starvation();
        bus.pipe_we = 1'b1; bus.pipe_rd = 5'd4; bus.pipe_data = 32'h40;
        bus.md_valid = 1'b1; bus.md_rd = 5'd10; bus.md_data = 32'h1010;
        step();
        bus.md_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            n_cmp++;
            if (bus.pipe_stall !== 1'b0) begin
                n_fail++;
                $display("FAIL starve_early[%0d]: got stall=%0b want 0", k, bus.pipe_stall);
            end
            bus.pipe_rd = 5'(4 + k); bus.pipe_data = 32'(k);
            step();
            n_cmp++;
            if ({bus.ctrl_writeEnable, bus.ctrl_writeReg} !== {1'b1, 5'(4 + k)}) begin
                n_fail++;
                $display("FAIL starve_pipe[%0d]: got we=%0b reg=%0d want 1/%0d", k, bus.ctrl_writeEnable, bus.ctrl_writeReg, 4 + k);
            end
        end
        n_cmp++;
        if (bus.pipe_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL starve_stall: got stall=%0b want 1", bus.pipe_stall);
        end
        bus.pipe_we = 1'b0;
        step();
        n_cmp++;
        if ({bus.ctrl_writeEnable, bus.ctrl_writeReg, bus.data_writeReg, bus.pipe_stall} !== {1'b1, 5'd10, 32'h1010, 1'b0}) begin
            n_fail++;
            $display("FAIL starve_drain: got we=%0b reg=%0d data=%h stall=%0b want 1/10/1010 stall=0", bus.ctrl_writeEnable, bus.ctrl_writeReg, bus.data_writeReg, bus.pipe_stall);
        end
        idle_inputs();
        step();
    endtask

    task automatic test_back_to_back();
        bus.md_valid = 1'b1; bus.md_rd = 5'd12; bus.md_data = 32'hC1;
        step();
        bus.md_rd = 5'd13; bus.md_data = 32'hC2;
        step();
        bus.md_valid = 1'b0;
        bus.ctrl_readRegA = 5'd13; bus.ctrl_readRegB = 5'd12;
        #1;
        n_cmp++;
        if ({bus.ctrl_writeEnable, bus.ctrl_writeReg, bus.data_writeReg, bus.md_ready, bus.hazard_A, bus.hazard_B} !== {1'b1, 5'd12, 32'hC1, 1'b1, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_pushpop: got we=%0b reg=%0d data=%h rdy/hA/hB=%b want 1/12/c1 rdy/hA/hB=110", bus.ctrl_writeEnable, bus.ctrl_writeReg, bus.data_writeReg, {bus.md_ready, bus.hazard_A, bus.hazard_B});
        end
        step();
        n_cmp++;
        if ({bus.ctrl_writeEnable, bus.ctrl_writeReg, bus.data_writeReg} !== {1'b1, 5'd13, 32'hC2}) begin
            n_fail++;
            $display("FAIL b2b_second: got we=%0b reg=%0d data=%h want 1/13/c2", bus.ctrl_writeEnable, bus.ctrl_writeReg, bus.data_writeReg);
        end
        step();
        n_cmp++;
        if (bus.ctrl_writeEnable !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_empty: got we=%0b want 0", bus.ctrl_writeEnable);
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        bus.pipe_we = 1'b1; bus.pipe_rd = 5'd2; bus.pipe_data = 32'h2;
        bus.md_valid = 1'b1; bus.md_rd = 5'd14; bus.md_data = 32'hE;
        step();
        bus.md_rd = 5'd15; bus.md_data = 32'hF;
        step();
        idle_inputs();
        bus.ctrl_readRegA = 5'd14; bus.ctrl_readRegB = 5'd15;
        #1;
        n_cmp++;
        if ({bus.md_ready, bus.hazard_A, bus.hazard_B, bus.ctrl_writeEnable} !== 4'b0111) begin
            n_fail++;
            $display("FAIL rstmid_pre: got rdy/hA/hB/we=%b want 0111", {bus.md_ready, bus.hazard_A, bus.hazard_B, bus.ctrl_writeEnable});
        end
        #1;
        ctrl_reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.ctrl_writeEnable, bus.ctrl_writeReg, bus.data_writeReg, bus.md_ready, bus.pipe_stall, bus.hazard_A, bus.hazard_B} !== {1'b0, 5'd0, 32'd0, 4'b1000}) begin
            n_fail++;
            $display("FAIL rstmid_async: got we=%0b reg=%0d data=%h rdy/stall/hA/hB=%b want 0/0/0 1000", bus.ctrl_writeEnable, bus.ctrl_writeReg, bus.data_writeReg, {bus.md_ready, bus.pipe_stall, bus.hazard_A, bus.hazard_B});
        end
        #3;
        ctrl_reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            n_cmp++;
            if (bus.ctrl_writeEnable !== 1'b0) begin
                n_fail++;
                $display("FAIL rstmid_nowrite[%0d]: got we=%0b reg=%0d want we=0", k, bus.ctrl_writeEnable, bus.ctrl_writeReg);
            end
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_pipe();
        test_md_r0();
        test_fill_drain();
        test_squash();
        test_starvation();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
